merlin_dtcm_ctrl: RTL and testbench

MERLIN_DTCM_CTRL -- requirements
Module: merlin_dtcm_ctrl

---
 rtl/merlin_dtcm_ctrl.sv | 144 ++++++++++++++
 tb/tb_merlin_dtcm_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merlin_dtcm_ctrl.sv
// merlin_dtcm_ctrl: single-cycle data tightly-coupled memory with a 2-entry response queue.
//
// Parameters
//   C_DEPTH_X   : log2 of the number of 32-bit words held
//   C_BASE_ADDR : byte base address of the window, aligned to 4*2^C_DEPTH_X
//
// Ports
//   clk_i, resetb_i (async active-low), clk_en_i (global clock enable)
//   Request : dreqready_o, dreqvalid_i, dreqsize_i, dreqwrite_i, dreqhpl_i, dreqaddr_i,
//             dreqdata_i
//   Response: drspvalid_o, drspready_i, drsprerr_o, drspwerr_o, drspdata_o
//
// Optional feature macro: MERLIN_DTCM_HPL_PROTECT_EN
//   When defined, stores with dreqhpl_i == 2'b00 into the upper half of the window fault.
module merlin_dtcm_ctrl #(
    parameter int unsigned C_DEPTH_X   = 10,
    parameter logic [31:0] C_BASE_ADDR = 32'h2000_0000
) (
    input  logic        clk_i,
    input  logic        resetb_i,
    input  logic        clk_en_i,
    output logic        dreqready_o,
    input  logic        dreqvalid_i,
    input  logic [1:0]  dreqsize_i,
    input  logic        dreqwrite_i,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic [31:0] dreqdata_i,
    output logic        drspvalid_o,
    input  logic        drspready_i,
    output logic        drsprerr_o,
    output logic        drspwerr_o,
    output logic [31:0] drspdata_o
);

    localparam int unsigned NumWords = 1 << C_DEPTH_X;

    logic [31:0]          mem [NumWords];
    logic [C_DEPTH_X-1:0] word_idx;

    // Queue entries are {rerr, werr, data}; entry0 is always the head.
    logic [1:0]  count;
    logic [33:0] entry0;
    logic [33:0] entry1;
    logic [33:0] new_entry;

    logic        in_window;
    logic        fault;
    logic        push;
    logic        pop;
    logic        mem_we;
    logic [3:0]  byte_en;
    logic [31:0] wdata;

    assign word_idx = dreqaddr_i[C_DEPTH_X+1:2];
    // Window is size-aligned, so a match on the bits above the offset is sufficient.
    assign in_window = (dreqaddr_i[31:C_DEPTH_X+2] == C_BASE_ADDR[31:C_DEPTH_X+2]);

`ifdef MERLIN_DTCM_HPL_PROTECT_EN
    logic hpl_fault;
    assign hpl_fault = dreqwrite_i && (dreqhpl_i == 2'b00) && dreqaddr_i[C_DEPTH_X+1];
`else
    logic hpl_fault;
    logic unused_hpl;
    assign hpl_fault  = 1'b0;
    assign unused_hpl = ^dreqhpl_i;
`endif

    always_comb begin
        fault   = !in_window || hpl_fault;
        byte_en = 4'b0000;
        wdata   = dreqdata_i;
        unique case (dreqsize_i)
            2'b00: begin
                byte_en = 4'b0001 << dreqaddr_i[1:0];
                wdata   = {4{dreqdata_i[7:0]}};
            end
            2'b01: begin
                fault   = fault || dreqaddr_i[0];
                byte_en = dreqaddr_i[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{dreqdata_i[15:0]}};
            end
            2'b10: begin
                fault   = fault || (dreqaddr_i[1:0] != 2'b00);
                byte_en = 4'b1111;
            end
            default: fault = 1'b1;
        endcase
    end

    assign dreqready_o = (count < 2'd2);
    assign drspvalid_o = (count != 2'd0);
    assign push        = clk_en_i && dreqvalid_i && dreqready_o;
    assign pop         = clk_en_i && drspvalid_o && drspready_i;
    assign mem_we      = push && dreqwrite_i && !fault;

    always_comb begin
        new_entry = {2'b00, 32'h0};
        if (fault) begin
            new_entry = {!dreqwrite_i, dreqwrite_i, dreqaddr_i};
        end else if (!dreqwrite_i) begin
            new_entry = {2'b00, mem[word_idx]};
        end
    end

    // Memory array is deliberately outside the reset domain.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && byte_en[b]) begin
                mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= new_entry;
                    end else begin
                        entry1 <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    entry1 <= '0;
                    count  <= count - 2'd1;
                end
                // Push needs count < 2 and pop needs count != 0, so count is 1 here.
                2'b11: entry0 <= new_entry;
                default: ;
            endcase
        end
    end

    assign {drsprerr_o, drspwerr_o, drspdata_o} = entry0;

endmodule

// File: tb/tb_merlin_dtcm_ctrl.sv
// tb_merlin_dtcm_ctrl: directed table, hand-written corner sequences and randomized traffic
// for merlin_dtcm_ctrl, compared against a behavioural model of memory plus response queue.
module tb_merlin_dtcm_ctrl;

    localparam logic [31:0] Base  = 32'h2000_0000;
    localparam int unsigned Words = 1024;
`ifdef MERLIN_DTCM_HPL_PROTECT_EN
    localparam bit Hpl = 1'b1;
`else
    localparam bit Hpl = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetb;
    logic        clk_en;
    logic        dreqready;
    logic        dreqvalid;
    logic [1:0]  dreqsize;
    logic        dreqwrite;
    logic [1:0]  dreqhpl;
    logic [31:0] dreqaddr;
    logic [31:0] dreqdata;
    logic        drspvalid;
    logic        drspready;
    logic        drsprerr;
    logic        drspwerr;
    logic [31:0] drspdata;

    merlin_dtcm_ctrl #(
        .C_DEPTH_X  (10),
        .C_BASE_ADDR(Base)
    ) dut (
        .clk_i      (clk),
        .resetb_i   (resetb),
        .clk_en_i   (clk_en),
        .dreqready_o(dreqready),
        .dreqvalid_i(dreqvalid),
        .dreqsize_i (dreqsize),
        .dreqwrite_i(dreqwrite),
        .dreqhpl_i  (dreqhpl),
        .dreqaddr_i (dreqaddr),
        .dreqdata_i (dreqdata),
        .drspvalid_o(drspvalid),
        .drspready_i(drspready),
        .drsprerr_o (drsprerr),
        .drspwerr_o (drspwerr),
        .drspdata_o (drspdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rerr;
        logic        werr;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [1:0]  hpl;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rerr;
        logic        werr;
        logic [31:0] rdata;
    } vec_t;

    logic [31:0] mmem [Words];
    rsp_t        exp_q[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    int          npops  = 0;
    bit          last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: decide fault from the address/size rules, then read or update mmem.
    function automatic rsp_t model(input logic wr, input logic [1:0] size, input logic [1:0] hpl,
                                   input logic [31:0] addr, input logic [31:0] data);
        rsp_t        r;
        longint      off;
        bit          flt;
        int          idx;
        int          o;
        logic [31:0] w;
        off = longint'(addr) - longint'(Base);
        flt = (off < 0) || (off >= 4 * Words);
        flt = flt || (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0);
        if (Hpl && wr && hpl == 2'd0 && off >= 2 * Words) flt = 1'b1;
        r = '0;
        if (flt) begin
            r.rerr = !wr;
            r.werr = wr;
            r.data = addr;
        end else begin
            idx = int'(off / 4);
            o   = int'(off % 4);
            if (!wr) begin
                r.data = mmem[idx];
            end else begin
                w = mmem[idx];
                if (size == 2'd0) w[8*o +: 8] = data[7:0];
                else if (size == 2'd1) w[8*o +: 16] = data[15:0];
                else w = data;
                mmem[idx] = w;
            end
        end
        return r;
    endfunction

    // One clock: check outputs against the model at the negedge, advance model across posedge.
    task automatic step();
        bit acc;
        bit pop;
        acc = clk_en && dreqvalid && (exp_q.size() < 2);
        pop = clk_en && drspready && (exp_q.size() != 0);
        chk("dreqready", 32'(dreqready), 32'(exp_q.size() < 2));
        chk("drspvalid", 32'(drspvalid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("rsp_rerr", 32'(drsprerr), 32'(exp_q[0].rerr));
            chk("rsp_werr", 32'(drspwerr), 32'(exp_q[0].werr));
            chk("rsp_data", drspdata, exp_q[0].data);
        end
        @(posedge clk);
        if (pop) begin
            void'(exp_q.pop_front());
            npops++;
        end
        if (acc) exp_q.push_back(model(dreqwrite, dreqsize, dreqhpl, dreqaddr, dreqdata));
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic req(input logic wr, input logic [1:0] size, input logic [1:0] hpl,
                       input logic [31:0] addr, input logic [31:0] data);
        dreqvalid = 1'b1;
        dreqwrite = wr;
        dreqsize  = size;
        dreqhpl   = hpl;
        dreqaddr  = addr;
        dreqdata  = data;
    endtask

    task automatic drain();
        dreqvalid = 1'b0;
        drspready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic void addv(input logic wr, input logic [1:0] size, input logic [1:0] hpl,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic rerr, input logic werr, input logic [31:0] rdata);
        vec_t v;
        v.wr = wr; v.size = size; v.hpl = hpl; v.addr = addr; v.data = data;
        v.rerr = rerr; v.werr = werr; v.rdata = rdata;
        vecs.push_back(v);
    endfunction

    initial begin
        int r;
        logic [31:0] a;

        addv(1, 2, 3, 32'h2000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0);
        addv(0, 2, 3, 32'h2000_0010, 32'h0,         0, 0, 32'hDEAD_BEEF);
        addv(1, 2, 3, 32'h2000_0010, 32'h1122_3344, 0, 0, 32'h0);
        addv(1, 0, 3, 32'h2000_0013, 32'h0000_00AA, 0, 0, 32'h0);
        addv(0, 2, 3, 32'h2000_0010, 32'h0,         0, 0, 32'hAA22_3344);
        addv(1, 2, 3, 32'h2000_0000, 32'h0000_0000, 0, 0, 32'h0);
        addv(0, 1, 3, 32'h2000_0001, 32'h0,         1, 0, 32'h2000_0001);
        addv(1, 2, 3, 32'h2000_1000, 32'h5555_5555, 0, 1, 32'h2000_1000);
        addv(0, 2, 3, 32'h2000_0000, 32'h0,         0, 0, 32'h0000_0000);
        addv(1, 1, 3, 32'h2000_0012, 32'h0000_BEEF, 0, 0, 32'h0);
        addv(0, 2, 3, 32'h2000_0010, 32'h0,         0, 0, 32'hBEEF_3344);
        addv(0, 3, 3, 32'h2000_0004, 32'h0,         1, 0, 32'h2000_0004);
        addv(1, 2, 3, 32'h2000_0006, 32'h1,         0, 1, 32'h2000_0006);
        addv(0, 2, 3, 32'h1FFF_FFFC, 32'h0,         1, 0, 32'h1FFF_FFFC);
        addv(1, 2, 3, 32'h2000_0FFC, 32'h1234_5678, 0, 0, 32'h0);
        addv(0, 2, 3, 32'h2000_0FFC, 32'h0,         0, 0, 32'h1234_5678);
        addv(1, 2, 3, 32'h2000_0800, 32'h0000_0000, 0, 0, 32'h0);
        addv(1, 2, 0, 32'h2000_0800, 32'hCAFE_F00D, 0, Hpl, Hpl ? 32'h2000_0800 : 32'h0);
        addv(0, 2, 0, 32'h2000_0800, 32'h0,         0, 0, Hpl ? 32'h0 : 32'hCAFE_F00D);
        addv(1, 2, 3, 32'h2000_0800, 32'h1357_9BDF, 0, 0, 32'h0);
        addv(0, 2, 3, 32'h2000_0800, 32'h0,         0, 0, 32'h1357_9BDF);

        resetb    = 1'b0;
        clk_en    = 1'b1;
        drspready = 1'b1;
        req(0, 2, 3, Base, 32'h0);
        dreqvalid = 1'b0;
        #1;
        chk("reset_ready", 32'(dreqready), 32'd1);
        chk("reset_valid", 32'(drspvalid), 32'd0);
        chk("reset_rerr", 32'(drsprerr), 32'd0);
        chk("reset_werr", 32'(drspwerr), 32'd0);
        chk("reset_data", drspdata, 32'd0);
        @(negedge clk);
        resetb = 1'b1;

        // Give every word a known value so the model can predict any load.
        for (int i = 0; i < int'(Words); i++) begin
            req(1, 2, 3, Base + 32'(4 * i), $urandom());
            step();
        end
        drain();

        foreach (vecs[i]) begin
            req(vecs[i].wr, vecs[i].size, vecs[i].hpl, vecs[i].addr, vecs[i].data);
            step();
            dreqvalid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(drspvalid), 32'd1);
            chk($sformatf("vec%0d_rerr", i), 32'(drsprerr), 32'(vecs[i].rerr));
            chk($sformatf("vec%0d_werr", i), 32'(drspwerr), 32'(vecs[i].werr));
            chk($sformatf("vec%0d_data", i), drspdata, vecs[i].rdata);
            step();
        end

        // Back-pressure: third request must stall until the consumer releases.
        drspready = 1'b0;
        req(1, 2, 3, 32'h2000_0020, 32'hA5A5_0F0F);
        step();
        req(0, 2, 3, 32'h2000_0020, 32'h0);
        step();
        req(0, 2, 3, 32'h2000_0010, 32'h0);
        chk("stall_ready", 32'(dreqready), 32'd0);
        for (int k = 0; k < 3; k++) step();
        chk("stall_ready_held", 32'(dreqready), 32'd0);
        drspready = 1'b1;
        npops     = 0;
        last_acc  = 1'b0;
        for (int k = 0; k < 5 && !last_acc; k++) step();
        chk("stall_third_accepted", 32'(last_acc), 32'd1);
        drain();
        chk("stall_pop_count", 32'(npops), 32'd3);

        // Clock enable low: nothing is accepted or popped.
        clk_en = 1'b0;
        req(1, 2, 3, 32'h2000_0020, 32'hFFFF_FFFF);
        step();
        step();
        chk("clken_no_push", 32'(drspvalid), 32'd0);
        clk_en = 1'b1;
        dreqvalid = 1'b0;

        // Reset with two responses pending; memory must survive.
        drspready = 1'b0;
        req(0, 2, 3, 32'h2000_0020, 32'h0);
        step();
        step();
        dreqvalid = 1'b0;
        chk("pre_reset_count2", 32'(dreqready), 32'd0);
        resetb = 1'b0;
        #1;
        chk("midreset_valid", 32'(drspvalid), 32'd0);
        chk("midreset_ready", 32'(dreqready), 32'd1);
        chk("midreset_data", drspdata, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        resetb    = 1'b1;
        drspready = 1'b1;
        req(0, 2, 3, 32'h2000_0020, 32'h0);
        step();
        dreqvalid = 1'b0;
        chk("post_reset_data", drspdata, 32'hA5A5_0F0F);
        step();

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) a = $urandom();
            else if (r == 1) a = Base + 32'h1000 + $urandom_range(0, 15);
            else if (r < 6) a = Base + $urandom_range(0, 63);
            else a = Base + $urandom_range(0, 4095);
            req(1'($urandom()), 2'($urandom()), 2'($urandom()), a, $urandom());
            dreqvalid = ($urandom_range(0, 3) != 0);
            drspready = ($urandom_range(0, 3) != 0);
            clk_en    = ($urandom_range(0, 9) != 0);
            step();
        end
        clk_en = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
